// File: rtl/rvfpm_xif_pkg.sv
// Shared types for the rvfpm CORE-V-XIF result path.
//   dest_e            : destination class of an offloaded instruction
//   DEST_W / FFLAGS_W : widths of the destination code and exception flags
//   dest_has_result() : 1 when the destination expects a result beat
package rvfpm_xif_pkg;

   localparam int DEST_W   = 2;
   localparam int FFLAGS_W = 5;

   typedef enum logic [DEST_W-1:0] {
      DEST_NONE = 2'd0,
      DEST_FREG = 2'd1,
      DEST_XREG = 2'd2,
      DEST_MEM  = 2'd3
   } dest_e;

   function automatic logic dest_has_result(input dest_e dest);
      return dest != DEST_NONE;
   endfunction

endpackage

// File: rtl/rvfpm_id_match.sv
// DEPTH-way id comparator for the result buffer.
//   id       : id to look up
//   ids_flat : entry ids, entry i at [i*X_ID_WIDTH +: X_ID_WIDTH]
//   qual     : per-entry qualifier (only qualified entries may match)
//   head_idx : slot of the oldest entry
//   match    : one-hot hit vector, all zero when nothing matches
module rvfpm_id_match #(
   parameter int DEPTH      = 8,
   parameter int X_ID_WIDTH = 4
) (
   input  logic [X_ID_WIDTH-1:0]       id,
   input  logic [DEPTH*X_ID_WIDTH-1:0] ids_flat,
   input  logic [DEPTH-1:0]            qual,
   input  logic [$clog2(DEPTH)-1:0]    head_idx,
   output logic [DEPTH-1:0]            match
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0] raw;
   logic [IDX_W-1:0] idx;
   logic             found;

   // Duplicate live ids are legal (they only raise err_id at issue), so the
   // oldest hit is chosen by scanning from the head.
   always_comb begin
      raw   = '0;
      match = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         raw[i] = qual[i] && (ids_flat[i*X_ID_WIDTH +: X_ID_WIDTH] == id);
      end
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_idx + IDX_W'(k);
         if (!found && raw[idx]) begin
            match[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rvfpm_xif_rob.sv
// In-order result buffer for offloaded FPU instructions on CORE-V-XIF.
// Tracks each instruction by XIF id from issue to retirement, absorbs
// out-of-order completions, applies commit/kill, and returns results in
// issue order.
//   clk_sys, rst_b          : clock, asynchronous active-low reset
//   issue_*                 : allocate handshake (id, destination)
//   cpl_*                   : completion strobe from the FPU (no backpressure)
//   commit_*                : commit / kill strobe from the core
//   result_*                : registered in-order result port (valid/ready)
//   occupancy               : live entries (tail - head)
//   err_id                  : one-cycle pulse on an illegal id event
module rvfpm_xif_rob
   import rvfpm_xif_pkg::*;
#(
   parameter int X_ID_WIDTH = 4,
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_sys,
   input  logic                    rst_b,
   input  logic                    issue_valid,
   output logic                    issue_ready,
   input  logic [X_ID_WIDTH-1:0]   issue_id,
   input  logic [DEST_W-1:0]       issue_dest,
   input  logic                    cpl_valid,
   input  logic [X_ID_WIDTH-1:0]   cpl_id,
   input  logic [DATA_WIDTH-1:0]   cpl_data,
   input  logic [FFLAGS_W-1:0]     cpl_fflags,
   input  logic                    commit_valid,
   input  logic [X_ID_WIDTH-1:0]   commit_id,
   input  logic                    commit_kill,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [X_ID_WIDTH-1:0]   result_id,
   output logic [DEST_W-1:0]       result_dest,
   output logic [DATA_WIDTH-1:0]   result_data,
   output logic [FFLAGS_W-1:0]     result_fflags,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    err_id
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef struct packed {
      logic                  valid;
      logic [X_ID_WIDTH-1:0] id;
      dest_e                 dest;
      logic                  done;
      logic                  committed;
      logic                  killed;
      logic [DATA_WIDTH-1:0] data;
      logic [FFLAGS_W-1:0]   fflags;
   } rob_entry_t;

   rob_entry_t rob_q [DEPTH];
   rob_entry_t rob_d [DEPTH];

   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic                  result_valid_q, result_valid_d;
   logic [X_ID_WIDTH-1:0] result_id_q, result_id_d;
   dest_e                 result_dest_q, result_dest_d;
   logic [DATA_WIDTH-1:0] result_data_q, result_data_d;
   logic [FFLAGS_W-1:0]   result_fflags_q, result_fflags_d;
   logic                  err_id_q, err_id_d;

   logic [IDX_W-1:0]            head_idx, tail_idx, next_idx;
   logic [PTR_W-1:0]            occ;
   logic                        full;
   logic                        issue_fire, res_hs, silent_ret, retire, dup_hit;
   logic [DEPTH*X_ID_WIDTH-1:0] ids_flat;
   logic [DEPTH-1:0]            cpl_qual, commit_qual, cpl_match, commit_match;
   rob_entry_t                  next_e;

   assign head_idx    = head_q[IDX_W-1:0];
   assign tail_idx    = tail_q[IDX_W-1:0];
   assign occ         = tail_q - head_q;
   assign full        = (occ == PTR_W'(DEPTH));
   // Registered occupancy only: a retire in this cycle does not free a slot yet.
   assign issue_ready = !full && rst_b;

   always_comb begin
      ids_flat    = '0;
      cpl_qual    = '0;
      commit_qual = '0;
      dup_hit     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ids_flat[i*X_ID_WIDTH +: X_ID_WIDTH] = rob_q[i].id;
         cpl_qual[i]    = rob_q[i].valid && !rob_q[i].done;
         commit_qual[i] = rob_q[i].valid && !rob_q[i].committed;
         if (rob_q[i].valid && (rob_q[i].id == issue_id)) begin
            dup_hit = 1'b1;
         end
      end
   end

   rvfpm_id_match #(
      .DEPTH      (DEPTH),
      .X_ID_WIDTH (X_ID_WIDTH)
   ) u_cpl_match (
      .id       (cpl_id),
      .ids_flat (ids_flat),
      .qual     (cpl_qual),
      .head_idx (head_idx),
      .match    (cpl_match)
   );

   rvfpm_id_match #(
      .DEPTH      (DEPTH),
      .X_ID_WIDTH (X_ID_WIDTH)
   ) u_commit_match (
      .id       (commit_id),
      .ids_flat (ids_flat),
      .qual     (commit_qual),
      .head_idx (head_idx),
      .match    (commit_match)
   );

   always_comb begin
      rob_d           = rob_q;
      head_d          = head_q;
      tail_d          = tail_q;
      result_valid_d  = result_valid_q;
      result_id_d     = result_id_q;
      result_dest_d   = result_dest_q;
      result_data_d   = result_data_q;
      result_fflags_d = result_fflags_q;
      err_id_d        = 1'b0;

      issue_fire = issue_valid && issue_ready;
      res_hs     = result_valid_q && result_ready;
      // A killed entry stays until its completion arrives, so the FPU's late
      // completion is absorbed instead of hitting a reused id or raising err_id.
      silent_ret = rob_q[head_idx].valid && rob_q[head_idx].done &&
                   (rob_q[head_idx].killed ||
                    (rob_q[head_idx].committed && !dest_has_result(rob_q[head_idx].dest)));
      retire     = silent_ret || res_hs;
      next_idx   = retire ? head_idx + IDX_W'(1) : head_idx;
      next_e     = rob_q[next_idx];

      if (issue_fire) begin
         rob_d[tail_idx]       = '0;
         rob_d[tail_idx].valid = 1'b1;
         rob_d[tail_idx].id    = issue_id;
         rob_d[tail_idx].dest  = dest_e'(issue_dest);
         tail_d                = tail_q + PTR_W'(1);
         if (dup_hit) begin
            err_id_d = 1'b1;
         end
      end

      if (cpl_valid) begin
         if (|cpl_match) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (cpl_match[i]) begin
                  rob_d[i].done   = 1'b1;
                  rob_d[i].data   = cpl_data;
                  rob_d[i].fflags = cpl_fflags;
               end
            end
         end else begin
            err_id_d = 1'b1;
         end
      end

      if (commit_valid) begin
         if (|commit_match) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (commit_match[i]) begin
                  rob_d[i].committed = 1'b1;
                  rob_d[i].killed    = commit_kill;
               end
            end
         end else begin
            err_id_d = 1'b1;
         end
      end

      if (retire) begin
         rob_d[head_idx].valid = 1'b0;
         head_d                = head_q + PTR_W'(1);
      end

      // Load the result register from the entry that will be at head after
      // this edge; it then holds until the handshake.
      if (!result_valid_q || res_hs) begin
         if (next_e.valid && next_e.done && next_e.committed && !next_e.killed &&
             dest_has_result(next_e.dest)) begin
            result_valid_d  = 1'b1;
            result_id_d     = next_e.id;
            result_dest_d   = next_e.dest;
            result_data_d   = next_e.data;
            result_fflags_d = next_e.fflags;
         end else begin
            result_valid_d  = 1'b0;
            result_id_d     = '0;
            result_dest_d   = DEST_NONE;
            result_data_d   = '0;
            result_fflags_d = '0;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i] <= '0;
         end
         head_q          <= '0;
         tail_q          <= '0;
         result_valid_q  <= 1'b0;
         result_id_q     <= '0;
         result_dest_q   <= DEST_NONE;
         result_data_q   <= '0;
         result_fflags_q <= '0;
         err_id_q        <= 1'b0;
      end else begin
         rob_q           <= rob_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         result_valid_q  <= result_valid_d;
         result_id_q     <= result_id_d;
         result_dest_q   <= result_dest_d;
         result_data_q   <= result_data_d;
         result_fflags_q <= result_fflags_d;
         err_id_q        <= err_id_d;
      end
   end

   assign result_valid  = result_valid_q;
   assign result_id     = result_id_q;
   assign result_dest   = result_dest_q;
   assign result_data   = result_data_q;
   assign result_fflags = result_fflags_q;
   assign occupancy     = occ;
   assign err_id        = err_id_q;

endmodule

// File: tb/tb_rvfpm_xif_rob.sv
// Bench for rvfpm_xif_rob: directed scenarios plus randomized batches
// checked against an issue-order result list.
module tb_rvfpm_xif_rob;

   localparam int XW    = 4;
   localparam int DEPTH = 8;
   localparam int DW    = 32;

   logic          clk_sys = 1'b0;
   logic          rst_b   = 1'b0;
   logic          issue_valid, issue_ready;
   logic [XW-1:0] issue_id;
   logic [1:0]    issue_dest;
   logic          cpl_valid;
   logic [XW-1:0] cpl_id;
   logic [DW-1:0] cpl_data;
   logic [4:0]    cpl_fflags;
   logic          commit_valid;
   logic [XW-1:0] commit_id;
   logic          commit_kill;
   logic          result_valid, result_ready;
   logic [XW-1:0] result_id;
   logic [1:0]    result_dest;
   logic [DW-1:0] result_data;
   logic [4:0]    result_fflags;
   logic [3:0]    occupancy;
   logic          err_id;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [XW-1:0] id;
      logic [1:0]    dest;
      logic [DW-1:0] data;
      logic [4:0]    ff;
   } res_t;

   rvfpm_xif_rob #(.X_ID_WIDTH(XW), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk_sys       (clk_sys),
      .rst_b         (rst_b),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_id      (issue_id),
      .issue_dest    (issue_dest),
      .cpl_valid     (cpl_valid),
      .cpl_id        (cpl_id),
      .cpl_data      (cpl_data),
      .cpl_fflags    (cpl_fflags),
      .commit_valid  (commit_valid),
      .commit_id     (commit_id),
      .commit_kill   (commit_kill),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .result_id     (result_id),
      .result_dest   (result_dest),
      .result_data   (result_data),
      .result_fflags (result_fflags),
      .occupancy     (occupancy),
      .err_id        (err_id)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic cyc();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle();
      issue_valid  = 1'b0;
      issue_id     = '0;
      issue_dest   = '0;
      cpl_valid    = 1'b0;
      cpl_id       = '0;
      cpl_data     = '0;
      cpl_fflags   = '0;
      commit_valid = 1'b0;
      commit_id    = '0;
      commit_kill  = 1'b0;
   endtask

   task automatic issue_one(input logic [XW-1:0] id, input logic [1:0] dest);
      issue_valid = 1'b1;
      issue_id    = id;
      issue_dest  = dest;
      cyc();
      issue_valid = 1'b0;
   endtask

   task automatic drive_cpl(input logic [XW-1:0] id, input logic [DW-1:0] d, input logic [4:0] ff);
      cpl_valid  = 1'b1;
      cpl_id     = id;
      cpl_data   = d;
      cpl_fflags = ff;
   endtask

   task automatic drive_commit(input logic [XW-1:0] id, input logic kill);
      commit_valid = 1'b1;
      commit_id    = id;
      commit_kill  = kill;
   endtask

   task automatic test_reset();
      idle();
      result_ready = 1'b0;
      rst_b = 1'b0;
      cyc(); cyc();
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready: got %0b want 0", issue_ready); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b want 0", result_valid); end
      checks++; if (result_data !== '0 || result_id !== '0) begin errors++; $display("FAIL reset_rdata: got %0h/%0h want 0", result_data, result_id); end
      checks++; if (err_id !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err_id); end
      rst_b = 1'b1;
      cyc();
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b want 1", issue_ready); end
   endtask

   task automatic test_ooo_completion();
      logic [DW-1:0] exp_d [3];
      res_t got[$];
      exp_d[0] = 32'h3F800000; exp_d[1] = 32'h40000000; exp_d[2] = 32'h40400000;
      result_ready = 1'b0;
      issue_one(4'd1, 2'd1); issue_one(4'd2, 2'd1); issue_one(4'd3, 2'd1);
      drive_cpl(4'd3, exp_d[2], 5'd3); cyc(); idle();
      drive_cpl(4'd1, exp_d[0], 5'd1); cyc(); idle();
      drive_cpl(4'd2, exp_d[1], 5'd2); cyc(); idle();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ooo_uncommitted_rvalid: got %0b want 0", result_valid); end
      for (int k = 1; k <= 3; k++) begin
         drive_commit(XW'(k), 1'b0); cyc(); idle();
      end
      result_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (result_valid) got.push_back(res_t'{result_id, result_dest, result_data, result_fflags});
         cyc();
      end
      result_ready = 1'b0;
      checks++; if (got.size() != 3) begin errors++; $display("FAIL ooo_count: got %0d want 3", got.size()); end
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         checks++;
         if (got[k].id !== XW'(k+1) || got[k].data !== exp_d[k] || got[k].ff !== 5'(k+1) || got[k].dest !== 2'd1) begin
            errors++;
            $display("FAIL ooo_result%0d: got id=%0d data=%h ff=%0d dest=%0d want id=%0d data=%h ff=%0d dest=1",
                     k, got[k].id, got[k].data, got[k].ff, got[k].dest, k+1, exp_d[k], k+1);
         end
      end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL ooo_occ: got %0d want 0", occupancy); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d [4];
      result_ready = 1'b0;
      for (int k = 0; k < 4; k++) issue_one(XW'(10+k), 2'd2);
      for (int k = 0; k < 4; k++) begin
         d[k] = $urandom;
         drive_cpl(XW'(10+k), d[k], 5'd0); drive_commit(XW'(10+k), 1'b0); cyc(); idle();
      end
      cyc();
      result_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (result_valid !== 1'b1 || result_id !== XW'(10+k) || result_data !== d[k]) begin
            errors++;
            $display("FAIL b2b_beat%0d: got v=%0b id=%0d data=%h want v=1 id=%0d data=%h", k, result_valid, result_id, result_data, 10+k, d[k]);
         end
         cyc();
      end
      checks++; if (result_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL b2b_drain: got v=%0b occ=%0d want v=0 occ=0", result_valid, occupancy); end
      result_ready = 1'b0;
   endtask

   task automatic test_full();
      int errs = 0;
      bit ok = 0;
      result_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) issue_one(XW'(k), 2'd0);
      checks++; if (issue_ready !== 1'b0 || occupancy !== 4'd8) begin errors++; $display("FAIL full_state: got rdy=%0b occ=%0d want rdy=0 occ=8", issue_ready, occupancy); end
      drive_cpl(4'd0, 32'h1234, 5'd0); drive_commit(4'd0, 1'b0); cyc(); idle();
      checks++; if (issue_ready !== 1'b0 || occupancy !== 4'd8) begin errors++; $display("FAIL full_before_retire: got rdy=%0b occ=%0d want rdy=0 occ=8", issue_ready, occupancy); end
      cyc();
      checks++; if (issue_ready !== 1'b1 || occupancy !== 4'd7) begin errors++; $display("FAIL full_after_retire: got rdy=%0b occ=%0d want rdy=1 occ=7", issue_ready, occupancy); end
      for (int k = 1; k < DEPTH; k++) begin
         drive_cpl(XW'(k), 32'h0, 5'd0); drive_commit(XW'(k), 1'b1); cyc(); idle();
         if (err_id) errs++;
      end
      for (int c = 0; c < 30 && !ok; c++) begin
         if (occupancy == 4'd0) ok = 1; else cyc();
         if (err_id) errs++;
      end
      checks++; if (!ok) begin errors++; $display("FAIL full_drain_timeout: occ=%0d want 0", occupancy); end
      checks++; if (errs != 0) begin errors++; $display("FAIL full_drain_err: got %0d pulses want 0", errs); end
      result_ready = 1'b0;
   endtask

   task automatic test_kill();
      int seen_v = 0, seen_e = 0;
      result_ready = 1'b1;
      issue_one(4'd5, 2'd1);
      drive_commit(4'd5, 1'b1); cyc(); idle();
      checks++; if (err_id !== 1'b0) begin errors++; $display("FAIL kill_commit_err: got %0b want 0", err_id); end
      drive_cpl(4'd5, 32'hDEAD, 5'd4); cyc(); idle();
      checks++; if (err_id !== 1'b0) begin errors++; $display("FAIL kill_cpl_err: got %0b want 0", err_id); end
      for (int c = 0; c < 5; c++) begin
         if (result_valid) seen_v++;
         if (err_id) seen_e++;
         cyc();
      end
      checks++; if (seen_v != 0 || seen_e != 0) begin errors++; $display("FAIL kill_silent: got rvalid=%0d err=%0d want 0/0", seen_v, seen_e); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL kill_occ: got %0d want 0", occupancy); end
      result_ready = 1'b0;
   endtask

   task automatic test_hold();
      logic [DW-1:0] d;
      d = $urandom;
      result_ready = 1'b0;
      issue_one(4'd4, 2'd2);
      drive_cpl(4'd4, d, 5'h11); cyc(); idle();
      drive_commit(4'd4, 1'b0); cyc(); idle();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL hold_no_bypass: got %0b want 0", result_valid); end
      cyc();
      checks++; if (result_valid !== 1'b1 || result_data !== d || result_fflags !== 5'h11) begin errors++; $display("FAIL hold_present: got v=%0b data=%h ff=%0h want v=1 data=%h ff=11", result_valid, result_data, result_fflags, d); end
      for (int i = 0; i < 4; i++) begin
         if (i == 1) drive_commit(4'd4, 1'b1);
         cyc(); idle();
         checks++; if (result_valid !== 1'b1 || result_data !== d || result_id !== 4'd4) begin errors++; $display("FAIL hold_stable%0d: got v=%0b data=%h id=%0d want v=1 data=%h id=4", i, result_valid, result_data, result_id, d); end
         if (i == 1) begin
            checks++; if (err_id !== 1'b1) begin errors++; $display("FAIL hold_kill_presented_err: got %0b want 1", err_id); end
         end
      end
      result_ready = 1'b1;
      cyc();
      checks++; if (result_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL hold_retire: got v=%0b occ=%0d want v=0 occ=0", result_valid, occupancy); end
      result_ready = 1'b0;
   endtask

   task automatic test_bad_id();
      result_ready = 1'b1;
      issue_one(4'd2, 2'd1);
      drive_cpl(4'd9, 32'hBAD, 5'd1); cyc(); idle();
      checks++; if (err_id !== 1'b1 || occupancy !== 4'd1) begin errors++; $display("FAIL badid_pulse: got err=%0b occ=%0d want err=1 occ=1", err_id, occupancy); end
      cyc();
      checks++; if (err_id !== 1'b0) begin errors++; $display("FAIL badid_one_cycle: got %0b want 0", err_id); end
      drive_cpl(4'd2, 32'h600D, 5'd0); drive_commit(4'd2, 1'b0); cyc(); idle();
      checks++; if (err_id !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL badid_entry_intact: got err=%0b v=%0b want 0/0", err_id, result_valid); end
      cyc();
      checks++; if (result_valid !== 1'b1 || result_id !== 4'd2 || result_data !== 32'h600D) begin errors++; $display("FAIL badid_result: got v=%0b id=%0d data=%h want 1/2/600d", result_valid, result_id, result_data); end
      cyc();
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL badid_occ: got %0d want 0", occupancy); end
      result_ready = 1'b0;
   endtask

   task automatic test_same_cycle_issue();
      bit ok = 0;
      issue_valid = 1'b1; issue_id = 4'd6; issue_dest = 2'd1;
      drive_cpl(4'd6, 32'h1, 5'd0);
      cyc(); idle();
      checks++; if (err_id !== 1'b1 || occupancy !== 4'd1) begin errors++; $display("FAIL same_cycle_err: got err=%0b occ=%0d want 1/1", err_id, occupancy); end
      drive_cpl(4'd6, 32'h1, 5'd0); drive_commit(4'd6, 1'b1); cyc(); idle();
      for (int c = 0; c < 10 && !ok; c++) begin
         if (occupancy == 4'd0) ok = 1; else cyc();
      end
      checks++; if (!ok) begin errors++; $display("FAIL same_cycle_drain: occ=%0d want 0", occupancy); end
   endtask

   task automatic test_random(input int batches);
      logic [XW-1:0] ids [8];
      logic [1:0]    dst [8];
      logic [DW-1:0] dat [8];
      logic [4:0]    ffl [8];
      bit            kil [8], iss [8], dn [8], cm [8];
      res_t          expq[$], gotq[$];
      int n, base, next_iss, issuing, cpl_k, cm_k, start, k, err_seen;
      bit fin, all_res;
      for (int b = 0; b < batches; b++) begin
         n = $urandom_range(1, DEPTH);
         base = $urandom_range(0, 15);
         expq.delete(); gotq.delete();
         for (int j = 0; j < 8; j++) begin
            ids[j] = XW'(base + j);
            dst[j] = 2'($urandom_range(0, 3));
            dat[j] = $urandom;
            ffl[j] = 5'($urandom_range(0, 31));
            kil[j] = ($urandom_range(0, 3) == 0);
            iss[j] = 0; dn[j] = 0; cm[j] = 0;
            if (j < n && !kil[j] && dst[j] != 2'd0) expq.push_back(res_t'{ids[j], dst[j], dat[j], ffl[j]});
         end
         next_iss = 0; err_seen = 0; fin = 0;
         for (int c = 0; c < 400 && !fin; c++) begin
            idle();
            result_ready = ($urandom_range(0, 2) != 0);
            issuing = -1; cpl_k = -1; cm_k = -1;
            if (next_iss < n && $urandom_range(0, 1) == 1) begin
               issue_valid = 1'b1; issue_id = ids[next_iss]; issue_dest = dst[next_iss];
               issuing = next_iss;
            end
            if ($urandom_range(0, 1) == 1) begin
               start = $urandom_range(0, n-1);
               for (int j = 0; j < n; j++) begin
                  k = (start + j) % n;
                  if (cpl_k < 0 && iss[k] && !dn[k]) cpl_k = k;
               end
               if (cpl_k >= 0) drive_cpl(ids[cpl_k], dat[cpl_k], ffl[cpl_k]);
            end
            if ($urandom_range(0, 1) == 1) begin
               start = $urandom_range(0, n-1);
               for (int j = 0; j < n; j++) begin
                  k = (start + j) % n;
                  if (cm_k < 0 && iss[k] && !cm[k]) cm_k = k;
               end
               if (cm_k >= 0) drive_commit(ids[cm_k], kil[cm_k]);
            end
            if (result_valid && result_ready) gotq.push_back(res_t'{result_id, result_dest, result_data, result_fflags});
            cyc();
            if (err_id) err_seen++;
            if (issuing >= 0) begin iss[issuing] = 1; next_iss++; end
            if (cpl_k >= 0) dn[cpl_k] = 1;
            if (cm_k >= 0) cm[cm_k] = 1;
            all_res = (next_iss == n);
            for (int j = 0; j < n; j++) if (!dn[j] || !cm[j]) all_res = 0;
            if (all_res && occupancy == 4'd0 && !result_valid) fin = 1;
         end
         idle();
         checks++; if (!fin) begin errors++; $display("FAIL rand%0d_timeout: occ=%0d want 0", b, occupancy); end
         checks++; if (err_seen != 0) begin errors++; $display("FAIL rand%0d_err: got %0d pulses want 0", b, err_seen); end
         checks++; if (gotq.size() != expq.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", b, gotq.size(), expq.size()); end
         for (int j = 0; j < expq.size() && j < gotq.size(); j++) begin
            checks++;
            if (gotq[j] != expq[j]) begin
               errors++;
               $display("FAIL rand%0d_res%0d: got id=%0d dest=%0d data=%h ff=%0h want id=%0d dest=%0d data=%h ff=%0h",
                        b, j, gotq[j].id, gotq[j].dest, gotq[j].data, gotq[j].ff, expq[j].id, expq[j].dest, expq[j].data, expq[j].ff);
            end
         end
      end
      result_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      result_ready = 1'b0;
      issue_one(4'd1, 2'd1); issue_one(4'd2, 2'd1); issue_one(4'd3, 2'd1);
      drive_cpl(4'd1, 32'hAAAA, 5'd0); drive_commit(4'd1, 1'b0); cyc(); idle();
      cyc();
      checks++; if (result_valid !== 1'b1 || occupancy !== 4'd3) begin errors++; $display("FAIL rstmid_pre: got v=%0b occ=%0d want 1/3", result_valid, occupancy); end
      #2 rst_b = 1'b0;
      #1;
      checks++; if (occupancy !== 4'd0 || result_valid !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL rstmid_async: got occ=%0d v=%0b rdy=%0b want 0/0/0", occupancy, result_valid, issue_ready); end
      cyc();
      rst_b = 1'b1;
      cyc();
      result_ready = 1'b1;
      issue_one(4'd1, 2'd1);
      drive_cpl(4'd1, 32'h5555, 5'd2); drive_commit(4'd1, 1'b0); cyc(); idle();
      cyc();
      checks++; if (result_valid !== 1'b1 || result_id !== 4'd1 || result_data !== 32'h5555 || result_fflags !== 5'd2) begin errors++; $display("FAIL rstmid_reissue: got v=%0b id=%0d data=%h ff=%0d want 1/1/5555/2", result_valid, result_id, result_data, result_fflags); end
      cyc();
      checks++; if (result_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL rstmid_final: got v=%0b occ=%0d want 0/0", result_valid, occupancy); end
      result_ready = 1'b0;
   endtask

   initial begin
      idle();
      result_ready = 1'b0;
      test_reset();
      test_ooo_completion();
      test_back_to_back();
      test_full();
      test_kill();
      test_hold();
      test_bad_id();
      test_same_cycle_issue();
      test_random(12);
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
